dbus_uart_tx: RTL and testbench

- Wishbone-classic responder on the J1 data bus (dbus) that implements a memory-mapped UART transmitter.
- The CPU writes bytes into a small FIFO. An 8N1 serializer drains the FIFO onto txd at a programmable bit rate.
- Sits beside the data RAM as a dbus target and provides a level interrupt for "transmit done".

---
 rtl/dbus_uart_tx.sv | 200 ++++++++++++++++++++
 tb/tb_dbus_uart_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_uart_tx.sv
`timescale 1ns / 1ps
// dbus_uart_tx: memory-mapped 8N1 UART transmitter on the J1 data bus (Wishbone classic).
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   dbus_cyc_i/stb_i    bus cycle / strobe; a request is cyc & stb & !ack
//   dbus_we_i           1 = write, 0 = read
//   dbus_adr_i          word address: 0 DATA, 1 STATUS, 2 DIVISOR, 3 reserved
//   dbus_dat_i/dat_o    write / read data (read data is 0 whenever ack is low)
//   dbus_ack_o          one-cycle acknowledge, the edge after the request
//   txd                 serial output, idles high
//   irq                 level: FIFO empty and serializer idle
module dbus_uart_tx #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd868
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dbus_cyc_i,
    input  logic                  dbus_stb_i,
    input  logic                  dbus_we_i,
    input  logic [1:0]            dbus_adr_i,
    input  logic [DATA_WIDTH-1:0] dbus_dat_i,
    output logic [DATA_WIDTH-1:0] dbus_dat_o,
    output logic                  dbus_ack_o,
    output logic                  txd,
    output logic                  irq
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [15:0]           div_q, div_d;
    logic [15:0]           div_frame_q, div_frame_d;
    logic [15:0]           timer_q, timer_d;
    logic [2:0]            bit_idx_q, bit_idx_d;
    logic [7:0]            shift_q, shift_d;
    logic                  ovr_q, ovr_d;
    logic                  txd_q, txd_d;
    logic                  irq_q, irq_d;
    logic [PtrW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [7:0]            mem_q [FIFO_DEPTH];

    logic                  req, wr, rd, push_req, push, pop, empty, full, busy, bit_end;
    logic [DATA_WIDTH-1:0] status;

    // Bus decode, register writes and FIFO bookkeeping.
    always_comb begin
        req      = dbus_cyc_i & dbus_stb_i & ~ack_q;
        wr       = req & dbus_we_i;
        rd       = req & ~dbus_we_i;
        empty    = (cnt_q == '0);
        full     = (cnt_q == CntW'(FIFO_DEPTH));
        busy     = ~empty | (state_q != StIdle);
        push_req = wr & (dbus_adr_i == 2'd0);
        // A full FIFO still accepts a byte when the serializer pops in the same cycle.
        push     = push_req & (~full | pop);

        status      = '0;
        status[0]   = busy;
        status[1]   = full;
        status[2]   = empty;
        status[3]   = ovr_q;
        status[7:4] = 4'(cnt_q);

        ack_d   = req;
        rdata_d = '0;
        if (rd) begin
            case (dbus_adr_i)
                2'd1:    rdata_d = status;
                2'd2:    rdata_d = DATA_WIDTH'(div_q);
                default: rdata_d = '0;
            endcase
        end

        div_d = div_q;
        if (wr && dbus_adr_i == 2'd2) div_d = dbus_dat_i[15:0];

        ovr_d = ovr_q;
        if (wr && dbus_adr_i == 2'd1 && dbus_dat_i[3]) ovr_d = 1'b0;
        if (push_req && full && !pop) ovr_d = 1'b1;

        wptr_d = push ? wptr_q + PtrW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + PtrW'(1) : rptr_q;
        cnt_d  = cnt_q;
        if (push && !pop) cnt_d = cnt_q + CntW'(1);
        if (pop && !push) cnt_d = cnt_q - CntW'(1);
    end

    // Serializer next state. The bit timer counts down from the divisor latched at frame start.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        div_frame_d = div_frame_q;
        pop         = 1'b0;
        bit_end     = (timer_q == 16'd0);

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    bit_idx_d = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) state_d = StStop;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_q != StIdle) timer_d = bit_end ? div_frame_q : timer_q - 16'd1;

        if (pop) begin
            shift_d     = mem_q[rptr_q];
            timer_d     = div_q;
            div_frame_d = div_q;
        end

        case (state_d)
            StStart: txd_d = 1'b0;
            StData:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
        irq_d = (cnt_d == '0) & (state_d == StIdle);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            div_q       <= DIV_RESET;
            div_frame_q <= DIV_RESET;
            timer_q     <= 16'd0;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            ovr_q       <= 1'b0;
            txd_q       <= 1'b1;
            irq_q       <= 1'b1;
            wptr_q      <= '0;
            rptr_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            div_q       <= div_d;
            div_frame_q <= div_frame_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            ovr_q       <= ovr_d;
            txd_q       <= txd_d;
            irq_q       <= irq_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            cnt_q       <= cnt_d;
        end
    end

    // FIFO storage holds only data, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= dbus_dat_i[7:0];
    end

    assign dbus_ack_o = ack_q;
    assign dbus_dat_o = rdata_q;
    assign txd        = txd_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_dbus_uart_tx.sv
`timescale 1ns / 1ps
module tb_dbus_uart_tx;

    logic        clk;
    logic        reset;
    logic        cyc, stb, we;
    logic [1:0]  adr;
    logic [15:0] wdat;
    logic [15:0] rdat;
    logic        ack;
    logic        txd;
    logic        irq;

    dbus_uart_tx #(
        .DATA_WIDTH(16),
        .FIFO_DEPTH(4),
        .DIV_RESET (16'd868)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .dbus_cyc_i(cyc),
        .dbus_stb_i(stb),
        .dbus_we_i (we),
        .dbus_adr_i(adr),
        .dbus_dat_i(wdat),
        .dbus_dat_o(rdat),
        .dbus_ack_o(ack),
        .txd       (txd),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t      exp_q[$];      // expected serial frames
    logic [15:0] rd_q[$];       // expected read data
    int          start_q[$];    // tick of each observed start bit
    int          n_cmp = 0;
    int          n_err = 0;
    int          frames_done = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = a; wdat = d;
        @(negedge clk);
        chk("wr_ack", ack, 1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic [15:0] e, input string tag);
        rd_q.push_back(e);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = a;
        @(negedge clk);
        chk("rd_ack", ack, 1);
        chk(tag, rdat, rd_q.pop_front());
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b, input int div);
        frame_t f;
        f.data = b;
        f.div  = div;
        exp_q.push_back(f);
        bus_write(2'd0, {8'h00, b});
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k = 0;
        while (frames_done < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("frames_done", frames_done, n);
    endtask

    initial begin
        int     frames_before;
        reset = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 2'd0; wdat = 16'h0;

        // Serial monitor: checks every txd sample of each frame against the scoreboard head.
        fork
            begin
                int     tick = 0;
                bit     active = 0;
                int     pos = 0;
                int     bad = 0;
                int     per;
                int     bitn;
                logic   expbit;
                frame_t cur;
                forever begin
                    @(negedge clk);
                    tick++;
                    if (reset) begin
                        active = 0;
                    end else begin
                        if (!active && txd === 1'b0) begin
                            chk("start_expected", exp_q.size() != 0, 1);
                            if (exp_q.size() != 0) begin
                                cur    = exp_q.pop_front();
                                active = 1;
                                pos    = 0;
                                bad    = 0;
                                start_q.push_back(tick);
                            end
                        end
                        if (active) begin
                            per  = cur.div + 1;
                            bitn = pos / per;
                            if (bitn == 0)      expbit = 1'b0;
                            else if (bitn <= 8) expbit = cur.data[bitn-1];
                            else                expbit = 1'b1;
                            if (txd !== expbit) bad++;
                            pos++;
                            if (pos == 10 * per) begin
                                chk("frame_bad_samples", bad, 0);
                                active = 0;
                                frames_done++;
                            end
                        end
                    end
                end
            end
        join_none

        // Values while in reset.
        #3;
        chk("rst_txd", txd, 1);
        chk("rst_irq", irq, 1);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: reset register values.
        bus_read(2'd1, 16'h0004, "status_reset");
        bus_read(2'd2, 16'h0364, "divisor_reset");
        bus_read(2'd0, 16'h0000, "data_read_zero");
        bus_read(2'd3, 16'h0000, "reg3_read_zero");
        chk("idle_txd", txd, 1);
        chk("idle_irq", irq, 1);

        // 2: single 0x55 frame at DIVISOR=3.
        bus_write(2'd2, 16'd3);
        push_byte(8'h55, 3);
        chk("pre_start_txd", txd, 1);
        chk("busy_irq", irq, 0);
        @(negedge clk);
        chk("start_latency_txd", txd, 0);
        wait_frames(1, 100);
        repeat (2) @(negedge clk);
        chk("done_irq", irq, 1);

        // 3: overflow and back-to-back frames.
        start_q.delete();
        push_byte(8'h01, 3);
        push_byte(8'h02, 3);
        push_byte(8'h03, 3);
        push_byte(8'h04, 3);
        push_byte(8'h05, 3);
        bus_write(2'd0, 16'h0006);              // FIFO full: dropped
        bus_read(2'd1, 16'h004B, "status_ovr");
        bus_write(2'd1, 16'h0008);
        bus_read(2'd1, 16'h0043, "status_ovr_cleared");
        wait_frames(6, 400);
        chk("burst_frames", start_q.size(), 5);
        for (int i = 1; i < 5 && i < start_q.size(); i++)
            chk("burst_gap", start_q[i] - start_q[i-1], 40);
        repeat (2) @(negedge clk);
        chk("burst_irq", irq, 1);

        // 4: held strobe gives alternating acks; stb without cyc is ignored.
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
        @(negedge clk);
        chk("held_ack_1", ack, 1);
        chk("held_dat_1", rdat, 16'd3);
        @(negedge clk);
        chk("held_ack_2", ack, 0);
        chk("held_dat_2", rdat, 16'd0);
        @(negedge clk);
        chk("held_ack_3", ack, 1);
        @(negedge clk);
        chk("held_ack_4", ack, 0);
        cyc = 1'b0; we = 1'b1; adr = 2'd0; wdat = 16'h0077;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nocyc_ack", ack, 0);
        end
        stb = 1'b0; we = 1'b0;
        bus_read(2'd1, 16'h0004, "nocyc_status");
        repeat (10) @(negedge clk);
        chk("nocyc_irq", irq, 1);

        // 5: DIVISOR change mid-frame applies from the next frame (model knows the order).
        start_q.delete();
        push_byte(8'hA5, 3);
        push_byte(8'h3C, 1);
        bus_write(2'd2, 16'd1);
        bus_read(2'd2, 16'd1, "divisor_readback");
        wait_frames(8, 300);
        chk("divchg_frames", start_q.size(), 2);
        if (start_q.size() >= 2) chk("divchg_gap", start_q[1] - start_q[0], 40);

        // 6: reset in the middle of a frame.
        bus_write(2'd2, 16'd3);
        push_byte(8'hF0, 3);
        repeat (20) @(negedge clk);
        frames_before = frames_done;
        #2 reset = 1'b1;
        #1;
        chk("midrst_txd", txd, 1);
        chk("midrst_irq", irq, 1);
        chk("midrst_ack", ack, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read(2'd1, 16'h0004, "midrst_status");
        bus_read(2'd2, 16'h0364, "midrst_divisor");
        repeat (100) @(negedge clk);
        chk("midrst_no_frames", frames_done, frames_before);
        chk("midrst_txd_idle", txd, 1);
        chk("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
